gecko_load_return: RTL and testbench
====================================

Name: gecko_load_return

Overview:
- Memory-return stage of the gecko core. Sits directly downstream of the execute stage's load issue.
- Queues the mem-operation descriptor of each issued load (destination register, funct3 load op, byte offset, speculative flag). Pairs each in-order memory response with the oldest queued descriptor.
- Aligns and sign/zero-extends the returned word using the package load-result rules. Emits a gecko_operation_t-shaped writeback result through a registered valid/ready output.

Parameters:
- DEPTH, 4, number of outstanding loads tracked; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  load descriptor offered by execute
- op_ready  out  1  descriptor accepted when op_valid && op_ready
- op_addr  in  5  destination register address (rv32_reg_addr_t)
- op_funct3  in  3  load op (rv32i_funct3_ls_t: B=0, H=1, W=2, BU=4, HU=5)
- op_offset  in  2  byte offset within word (gecko_byte_offset_t)
- op_speculative  in  1  speculative flag carried to writeback
- resp_valid  in  1  memory read data valid
- resp_ready  out  1  memory read data accepted when resp_valid && resp_ready
- resp_data  in  32  raw aligned 32-bit memory word
- wb_valid  out  1  writeback result valid
- wb_ready  in  1  writeback consumer ready
- wb_value  out  32  formatted load value
- wb_addr  out  5  destination register
- wb_speculative  out  1  speculative flag of the load
- outstanding  out  $clog2(DEPTH)+1  descriptors queued (not yet paired)
- error  out  1  sticky: response arrived with no outstanding descriptor

Behaviour:
- Reset: FIFO pointers and outstanding = 0; wb_valid, wb_value, wb_addr, wb_speculative, error = 0. Reset mid-operation discards all queued descriptors and any held output.
- Descriptor FIFO holds DEPTH entries. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. outstanding is the occupancy.
- op_ready = (outstanding != DEPTH). It does not depend on a same-cycle pop: a full FIFO rejects a push even when a pop occurs that cycle.
- out_free = !wb_valid || wb_ready.
- resp_ready = (outstanding != 0) && out_free. There is no bypass: a descriptor pushed in cycle N can pair with a response no earlier than cycle N+1.
- Response handshake (cycle N): pop the FIFO head. In cycle N+1: wb_valid=1, wb_addr=head.addr, wb_speculative=head.speculative, wb_value=format(resp_data, head.offset, head.funct3). Latency is 1 cycle.
- format rules:
  - b = resp_data >> (offset*8); h = resp_data >> (offset[1]*16).
  - B -> sign-extend b[7:0]; BU -> zero-extend b[7:0].
  - H -> sign-extend h[15:0]; HU -> zero-extend h[15:0]; offset[0] is ignored for halfwords.
  - W and all other codes -> resp_data unchanged.
- Output hold: while wb_valid && !wb_ready, all wb_* outputs are stable and resp_ready=0.
- Output release: wb_valid && wb_ready with no new response in the same cycle -> wb_valid=0 next cycle. A same-cycle new response reloads the output, giving back-to-back throughput of 1 per cycle.
- Simultaneous push and pop: outstanding unchanged. Both pointers advance.
- error protocol violation:
  - A response with resp_valid=1 while outstanding==0 is not accepted (resp_ready=0).
  - If it persists, error sets in that cycle (visible next cycle) and stays 1 until rst.
  - Set condition: resp_valid && outstanding==0 && out_free. This prevents stalled-output cycles from flagging.
- Descriptor data is captured only on handshake. op_* and resp_data are don't-care otherwise.

Test Plan:
- Byte sign-extend: push {addr=5, LB, offset=3, spec=0}; next cycle resp 0x80FF1234 -> one cycle later wb_valid=1, wb_value=0xFFFFFF80, wb_addr=5, outstanding=0.
- Halfword variants: push {addr=7, LHU, offset=2}, {addr=8, LH, offset=3}, {addr=9, LW, offset=1}; respond 0xBEEF0001, 0x8001AAAA, 0x12345678 -> wb_value 0x0000BEEF, 0xFFFF8001, 0x12345678 in order; addrs 7, 8, 9.
- Full FIFO (DEPTH=4): push 4 descriptors with no responses -> outstanding=4, op_ready=0.
  - Push and response the same cycle -> push refused, outstanding=3.
  - Next cycle, push and pop together -> outstanding stays 3.
- Backpressure: wb_ready=0 with 2 queued and resp_valid=1 -> first result held stable, resp_ready=0, second response not consumed. Raise wb_ready -> results drain on consecutive cycles.
- Protocol error: outstanding=0, resp_valid=1 for one cycle -> resp_ready=0, error=1 next cycle and stays 1; wb_valid remains 0; rst clears error.
- Reset mid-flight: 3 queued, wb_valid=1 held -> assert rst one cycle -> outstanding=0, wb_valid=0, op_ready=1, error=0. A subsequent LBU offset=1, resp 0x0000FF00 -> wb_value=0x000000FF.

Source files
------------

// File: rtl/gecko_load_return.sv
// Memory-return stage: queues load descriptors, pairs them with in-order memory
// responses, and formats the returned word into a registered writeback result.
module gecko_load_return #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [4:0]               op_addr,
   input  logic [2:0]               op_funct3,
   input  logic [1:0]               op_offset,
   input  logic                     op_speculative,
   input  logic                     resp_valid,
   output logic                     resp_ready,
   input  logic [31:0]              resp_data,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [31:0]              wb_value,
   output logic [4:0]               wb_addr,
   output logic                     wb_speculative,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     error
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef struct packed {
      logic [4:0] addr;
      logic [2:0] funct3;
      logic [1:0] offset;
      logic       spec;
   } desc_t;

   // Byte/halfword select plus sign/zero extension of a returned word.
   function automatic logic [31:0] format_load(input logic [31:0] data,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'd0:    b = data[7:0];
         2'd1:    b = data[15:8];
         2'd2:    b = data[23:16];
         default: b = data[31:24];
      endcase
      h = off[1] ? data[31:16] : data[15:0];
      case (f3)
         3'd0:    res = {{24{b[7]}}, b};
         3'd4:    res = {24'd0, b};
         3'd1:    res = {{16{h[15]}}, h};
         3'd5:    res = {16'd0, h};
         default: res = data;
      endcase
      return res;
   endfunction

   desc_t            fifo_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wb_valid_q, wb_valid_d;
   logic [31:0]      wb_value_q, wb_value_d;
   logic [4:0]       wb_addr_q, wb_addr_d;
   logic             wb_spec_q, wb_spec_d;
   logic             error_q, error_d;
   logic             out_free_s, push_s, pop_s;
   desc_t            head_s, desc_in_s;

   assign head_s    = fifo_q[rd_ptr_q];
   assign desc_in_s = '{addr: op_addr, funct3: op_funct3, offset: op_offset, spec: op_speculative};

   always_comb begin
      out_free_s = !wb_valid_q || wb_ready;
      op_ready   = (count_q != FULL_CNT);
      resp_ready = (count_q != {CW{1'b0}}) && out_free_s;
      push_s     = op_valid && op_ready;
      pop_s      = resp_valid && resp_ready;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wb_valid_d = wb_valid_q;
      wb_value_d = wb_value_q;
      wb_addr_d  = wb_addr_q;
      wb_spec_d  = wb_spec_q;
      error_d    = error_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end

      // A new response reloads the output; otherwise a consumed result retires.
      if (pop_s) begin
         wb_valid_d = 1'b1;
         wb_value_d = format_load(resp_data, head_s.offset, head_s.funct3);
         wb_addr_d  = head_s.addr;
         wb_spec_d  = head_s.spec;
      end else if (wb_valid_q && wb_ready) begin
         wb_valid_d = 1'b0;
      end else begin
         wb_valid_d = wb_valid_q;
      end

      // Stalled-output cycles must not flag an orphan response.
      if (resp_valid && (count_q == {CW{1'b0}}) && out_free_s) begin
         error_d = 1'b1;
      end else begin
         error_d = error_q;
      end
   end

   // Descriptor storage, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_q[wr_ptr_q] <= desc_in_s;
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         wb_valid_q <= 1'b0;
         wb_value_q <= 32'd0;
         wb_addr_q  <= 5'd0;
         wb_spec_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wb_valid_q <= wb_valid_d;
         wb_value_q <= wb_value_d;
         wb_addr_q  <= wb_addr_d;
         wb_spec_q  <= wb_spec_d;
         error_q    <= error_d;
      end
   end

   assign wb_valid       = wb_valid_q;
   assign wb_value       = wb_value_q;
   assign wb_addr        = wb_addr_q;
   assign wb_speculative = wb_spec_q;
   assign outstanding    = count_q;
   assign error          = error_q;

endmodule

// File: tb/tb_gecko_load_return.sv
// Self-checking bench for gecko_load_return: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_gecko_load_return;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, op_valid, op_ready, op_speculative;
   logic [4:0]  op_addr;
   logic [2:0]  op_funct3;
   logic [1:0]  op_offset;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic        wb_valid, wb_ready, wb_speculative;
   logic [31:0] wb_value;
   logic [4:0]  wb_addr;
   logic [2:0]  outstanding;
   logic        error;

   int total = 0;
   int bad   = 0;

   gecko_load_return #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready), .op_addr(op_addr),
      .op_funct3(op_funct3), .op_offset(op_offset), .op_speculative(op_speculative),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_value(wb_value),
      .wb_addr(wb_addr), .wb_speculative(wb_speculative),
      .outstanding(outstanding), .error(error)
   );

   always #5 clk = ~clk;

   // Reference formatting from the load-result rules, plain arithmetic.
   function automatic logic [31:0] ref_format(input logic [31:0] d, input int off, input int f3);
      int unsigned b, h;
      b = (d >> (off * 8)) & 32'hFF;
      h = (d >> ((off / 2) * 16)) & 32'hFFFF;
      if (f3 == 0)      return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      else if (f3 == 4) return b;
      else if (f3 == 1) return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      else if (f3 == 5) return h;
      else              return d;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      op_valid = 1'b0; op_addr = 5'd0; op_funct3 = 3'd0; op_offset = 2'd0;
      op_speculative = 1'b0; resp_valid = 1'b0; resp_data = 32'd0; wb_ready = 1'b1;
   endtask

   task automatic push(input logic [4:0] a, input logic [2:0] f, input logic [1:0] o, input logic s);
      op_valid = 1'b1; op_addr = a; op_funct3 = f; op_offset = o; op_speculative = s;
      cyc();
      op_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      do_reset();
      #1;
      total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
      total++; if (wb_valid !== 1'b0 || wb_value !== 32'd0 || wb_addr !== 5'd0 || wb_speculative !== 1'b0) begin
         bad++; $display("FAIL reset_wb got v=%b val=%h a=%0d s=%b exp all 0", wb_valid, wb_value, wb_addr, wb_speculative); end
      total++; if (error !== 1'b0 || op_ready !== 1'b1 || resp_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl got err=%b opr=%b rsr=%b exp 0/1/0", error, op_ready, resp_ready); end
   endtask

   task automatic test_byte();
      push(5'd5, 3'd0, 2'd3, 1'b0);
      resp_valid = 1'b1; resp_data = 32'h80FF_1234; #1;
      total++; if (resp_ready !== 1'b1) begin bad++; $display("FAIL byte_resp_ready got=%b exp=1", resp_ready); end
      cyc();
      resp_valid = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_value !== 32'hFFFF_FF80 || wb_addr !== 5'd5 || outstanding !== 3'd0) begin
         bad++; $display("FAIL byte_sext got v=%b val=%h a=%0d n=%0d exp 1 ffffff80 5 0", wb_valid, wb_value, wb_addr, outstanding); end
      cyc();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL byte_release got=%b exp=0", wb_valid); end
   endtask

   task automatic test_half();
      logic [31:0] data [3];
      logic [31:0] expv [3];
      logic [4:0]  expa [3];
      data = '{32'hBEEF_0001, 32'h8001_AAAA, 32'h1234_5678};
      expv = '{32'h0000_BEEF, 32'hFFFF_8001, 32'h1234_5678};
      expa = '{5'd7, 5'd8, 5'd9};
      push(5'd7, 3'd5, 2'd2, 1'b0);
      push(5'd8, 3'd1, 2'd3, 1'b1);
      push(5'd9, 3'd2, 2'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         resp_valid = 1'b1; resp_data = data[i];
         cyc();
         total++; if (wb_valid !== 1'b1 || wb_value !== expv[i] || wb_addr !== expa[i]) begin
            bad++; $display("FAIL half_%0d got v=%b val=%h a=%0d exp 1 %h %0d", i, wb_valid, wb_value, wb_addr, expv[i], expa[i]); end
      end
      resp_valid = 1'b0;
      cyc();
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) push(5'(i + 1), 3'd2, 2'd0, 1'b0);
      #1;
      total++; if (outstanding !== 3'd4 || op_ready !== 1'b0) begin
         bad++; $display("FAIL full_occupancy got n=%0d opr=%b exp 4 0", outstanding, op_ready); end
      op_valid = 1'b1; op_addr = 5'd20; op_funct3 = 3'd2; resp_valid = 1'b1; resp_data = 32'hA5A5_0001;
      cyc();
      total++; if (outstanding !== 3'd3 || wb_addr !== 5'd1) begin
         bad++; $display("FAIL full_push_refused got n=%0d a=%0d exp 3 1", outstanding, wb_addr); end
      op_addr = 5'd21; resp_data = 32'hA5A5_0002; #1;
      total++; if (op_ready !== 1'b1 || resp_ready !== 1'b1) begin
         bad++; $display("FAIL full_both_ready got opr=%b rsr=%b exp 1 1", op_ready, resp_ready); end
      cyc();
      op_valid = 1'b0;
      total++; if (outstanding !== 3'd3 || wb_value !== 32'hA5A5_0002) begin
         bad++; $display("FAIL full_push_pop got n=%0d val=%h exp 3 a5a50002", outstanding, wb_value); end
      for (int i = 0; i < 3; i++) cyc();
      resp_valid = 1'b0;
      total++; if (wb_addr !== 5'd21 || outstanding !== 3'd0) begin
         bad++; $display("FAIL full_drain got a=%0d n=%0d exp 21 0", wb_addr, outstanding); end
      cyc();
   endtask

   task automatic test_backpressure();
      push(5'd10, 3'd2, 2'd0, 1'b1);
      push(5'd11, 3'd2, 2'd0, 1'b0);
      wb_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hCAFE_0001;
      cyc();
      resp_data = 32'hCAFE_0002;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (resp_ready !== 1'b0 || wb_valid !== 1'b1 || wb_value !== 32'hCAFE_0001 ||
                      wb_addr !== 5'd10 || wb_speculative !== 1'b1 || outstanding !== 3'd1) begin
            bad++; $display("FAIL bp_hold_%0d got rsr=%b v=%b val=%h a=%0d s=%b n=%0d exp 0 1 cafe0001 10 1 1",
                            i, resp_ready, wb_valid, wb_value, wb_addr, wb_speculative, outstanding); end
         cyc();
      end
      wb_ready = 1'b1;
      cyc();
      resp_valid = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_value !== 32'hCAFE_0002 || wb_addr !== 5'd11 || wb_speculative !== 1'b0) begin
         bad++; $display("FAIL bp_drain got v=%b val=%h a=%0d s=%b exp 1 cafe0002 11 0", wb_valid, wb_value, wb_addr, wb_speculative); end
      cyc();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", wb_valid); end
   endtask

   task automatic test_error();
      resp_valid = 1'b1; resp_data = 32'h1111_1111; #1;
      total++; if (resp_ready !== 1'b0) begin bad++; $display("FAIL err_resp_ready got=%b exp=0", resp_ready); end
      cyc();
      resp_valid = 1'b0;
      total++; if (error !== 1'b1 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL err_set got err=%b v=%b exp 1 0", error, wb_valid); end
      for (int i = 0; i < 3; i++) cyc();
      total++; if (error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", error); end
      do_reset();
      total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", error); end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < DEPTH; i++) push(5'(i + 12), 3'd2, 2'd0, 1'b1);
      wb_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h5555_AAAA;
      cyc();
      resp_valid = 1'b0;
      total++; if (wb_valid !== 1'b1 || outstanding !== 3'd3) begin
         bad++; $display("FAIL mid_setup got v=%b n=%0d exp 1 3", wb_valid, outstanding); end
      do_reset();
      wb_ready = 1'b1;
      total++; if (outstanding !== 3'd0 || wb_valid !== 1'b0 || op_ready !== 1'b1 || error !== 1'b0) begin
         bad++; $display("FAIL mid_reset got n=%0d v=%b opr=%b err=%b exp 0 0 1 0", outstanding, wb_valid, op_ready, error); end
      push(5'd3, 3'd4, 2'd1, 1'b0);
      resp_valid = 1'b1; resp_data = 32'h0000_FF00;
      cyc();
      resp_valid = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_value !== 32'h0000_00FF || wb_addr !== 5'd3) begin
         bad++; $display("FAIL mid_lbu got v=%b val=%h a=%0d exp 1 000000ff 3", wb_valid, wb_value, wb_addr); end
      cyc();
   endtask

   typedef struct { int addr; int f3; int off; int spec; } ref_desc_t;

   task automatic test_random();
      ref_desc_t  q[$];
      ref_desc_t  d;
      int         m_valid, m_addr, m_spec, m_err, m_free, m_opr, m_rsr;
      logic [31:0] m_value;
      logic [2:0] f3_tab [6];
      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7};
      idle_inputs();
      do_reset();
      m_valid = 0; m_addr = 0; m_spec = 0; m_err = 0; m_value = 32'd0;
      for (int cycle = 0; cycle < 400; cycle++) begin
         op_valid       = ($urandom_range(0, 99) < 55);
         op_addr        = 5'($urandom);
         op_funct3      = f3_tab[$urandom_range(0, 5)];
         op_offset      = 2'($urandom);
         op_speculative = 1'($urandom);
         resp_valid     = (q.size() == 0) ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 50);
         resp_data      = $urandom;
         wb_ready       = ($urandom_range(0, 99) < 70);
         #1;
         m_free = (!m_valid || wb_ready) ? 1 : 0;
         m_opr  = (q.size() != DEPTH) ? 1 : 0;
         m_rsr  = (q.size() != 0 && m_free) ? 1 : 0;
         total++; if (op_ready !== 1'(m_opr) || resp_ready !== 1'(m_rsr)) begin
            bad++; $display("FAIL rnd_ready c=%0d got opr=%b rsr=%b exp %0d %0d", cycle, op_ready, resp_ready, m_opr, m_rsr); end
         if (resp_valid && q.size() == 0 && m_free) m_err = 1;
         if (resp_valid && m_rsr) begin
            d = q.pop_front();
            m_valid = 1; m_addr = d.addr; m_spec = d.spec;
            m_value = ref_format(resp_data, d.off, d.f3);
         end else if (m_valid && wb_ready) begin
            m_valid = 0;
         end
         if (op_valid && m_opr) q.push_back('{int'(op_addr), int'(op_funct3), int'(op_offset), int'(op_speculative)});
         cyc();
         total++; if (wb_valid !== 1'(m_valid) || outstanding !== 3'(q.size()) || error !== 1'(m_err)) begin
            bad++; $display("FAIL rnd_state c=%0d got v=%b n=%0d err=%b exp %0d %0d %0d",
                            cycle, wb_valid, outstanding, error, m_valid, q.size(), m_err); end
         if (m_valid) begin
            total++; if (wb_value !== m_value || wb_addr !== 5'(m_addr) || wb_speculative !== 1'(m_spec)) begin
               bad++; $display("FAIL rnd_data c=%0d got val=%h a=%0d s=%b exp %h %0d %0d",
                               cycle, wb_value, wb_addr, wb_speculative, m_value, m_addr, m_spec); end
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_byte();
      test_half();
      test_full();
      test_backpressure();
      test_error();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
